fpu_to_fixed: RTL and testbench
===============================

# fpu_to_fixed

Converts a 32-bit operand in the team's custom float format (1 sign bit, 6-bit exponent with bias 31, 25-bit mantissa with a hidden leading one) into a signed 32-bit two's-complement fixed-point word. It decodes what `fpu` encodes: `fpu` `data_out` feeds `op_in` here, and `data_out` here goes to fixed-point consumers. It is multi-cycle, using an iterative one-bit-per-cycle shifter. Handshakes are valid/ready on both sides. The 4-bit status word has the same shape as `fpu`.

## Interface
Parameters:
- `FRAC_BITS`, default 16: fractional bits of the output (Q(32-FRAC_BITS).FRAC_BITS). Legal range 0..30.

Ports:
- `clock100KHz` input 1: the only clock. All logic is rising-edge.
- `reset` input 1: synchronous, active-high reset.
- `op_in` input 32: float operand, laid out as {s, e[5:0], m[24:0]}.
- `op_valid_in` input 1: `op_in` is valid.
- `op_ready_out` output 1: block is in IDLE and can accept an operand.
- `data_out` output 32: signed fixed-point result.
- `data_valid_out` output 1: `data_out` and `status_out` are valid.
- `data_ready_in` input 1: consumer accepts the result.
- `status_out` output 4: [0] EXACT, [1] OVERFLOW, [2] UNDERFLOW, [3] INEXACT.

## Operation
- Value = (-1)^s × 1.m × 2^(e-31).
- Significand `sig` = {1, m}, 26 bits. Shift count `k` = (e-31) + FRAC_BITS - 25, a signed 7-bit value.
- States:
  - IDLE: `op_ready_out`=1. Accept when `op_valid_in` && `op_ready_out`; capture s, e, m, k.
  - SHIFT: shifts one position per cycle, |k| cycles in total.
    - Left shift when k>0.
    - Right shift when k<0. Bits shifted out update guard (last bit out) and sticky (OR of all earlier bits out).
  - ROUND: 1 cycle. Round to nearest, ties to even, on guard/sticky. Then apply the sign (two's complement).
  - DONE: `data_valid_out`=1, output held stable. When `data_ready_in`=1, go to IDLE on the next edge.
- Special cases are decided at accept and jump straight to DONE (no SHIFT or ROUND):
  - e==0, m==0 (including -0): result 0x0000_0000, status EXACT.
  - e==0, m≠0: flushed to zero, status UNDERFLOW|INEXACT.
  - k>6, or k==6 with (s==0 or m≠0): saturate to 0x7FFF_FFFF (s=0) or 0x8000_0000 (s=1), status OVERFLOW.
  - k<-26: result 0, status UNDERFLOW|INEXACT.
- k==6, s==1, m==0 is the exact value -2^31. It takes the normal path and returns 0x8000_0000 with status EXACT.
- Status on the normal path: EXACT if guard|sticky==0, otherwise INEXACT. Exactly one of EXACT or INEXACT is set. OVERFLOW and UNDERFLOW are 0 on this path.
- Back-to-back operands are not overlapped. `op_ready_out`=0 in every state except IDLE.

## Timing
- Reset, effective at the next edge:
  - state = IDLE, so `op_ready_out`=1 after the reset edge;
  - `data_out` = 0, `data_valid_out` = 0, `status_out` = 0;
  - shifter, guard and sticky cleared.
- Reset mid-operation abandons the conversion with no output.
- Latency, with accept at edge t:
  - Normal path: `data_valid_out` rises at edge t+|k|+2.
  - k=0: SHIFT is skipped, so t+2.
  - Special cases: t+1.
- `data_valid_out` stays high until the edge where `data_ready_in`=1. It is low from the following cycle.
- `op_ready_out` returns high in that same following cycle, so the minimum issue interval is latency + 1.
- `op_in` need not be held after the accept edge. `op_valid_in` is ignored outside IDLE.

## Configuration
- `FPU_FIXED_ROUND_EN` defined: ROUND performs round-to-nearest-even as described.
- Not defined:
  - Truncation toward zero (the magnitude is truncated, then the sign applied).
  - The ROUND state is merged into the last SHIFT cycle, so normal-path latency is t+|k|+1 (t+1 when k=0).
  - EXACT/INEXACT are still reported from guard|sticky.

## Structure
- `fpu_pkg` holds: EXP_W=6, MAN_W=25, BIAS=31, the status bit index constants, the float struct typedef {sign, exp, man}, and the state enum. These are shared with `fpu`.
- One sub-module, `fpu_fixed_round`: combinational guard/sticky rounding plus sign application. Its rounding logic is compiled out when `FPU_FIXED_ROUND_EN` is undefined.

## Test plan
All cases use FRAC_BITS=16 and round enabled.
- {0,31,0} (+1.0) → 0x0001_0000, EXACT. `data_valid_out` 11 cycles after accept (k=-9).
- {1,32,0} (-2.0) → 0xFFFE_0000, EXACT. {0,0,0} and {1,0,0} → 0x0000_0000, EXACT, 1-cycle latency.
- {0,14,1<<24} (0.75 LSB) → 0x0000_0001, INEXACT. {0,14,0} (0.5 LSB, tie) → 0x0000_0000, INEXACT.
- {0,63,all-ones} → 0x7FFF_FFFF, OVERFLOW. {1,46,0} → 0x8000_0000, EXACT. {0,46,0} → 0x7FFF_FFFF, OVERFLOW.
- {0,1,1} → 0, UNDERFLOW|INEXACT. Hold `data_ready_in`=0 for 5 cycles: output stays stable and `op_ready_out` stays 0.
- Assert `reset` during SHIFT of a k=-9 conversion: next cycle `data_valid_out`=0 and `op_ready_out`=1. A fresh operand then converts correctly.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the custom float format {sign, exp[5:0], man[24:0]},
// used by fpu and by the fpu_to_fixed converter.
package fpu_pkg;

    localparam int EXP_W  = 6;
    localparam int MAN_W  = 25;
    localparam int BIAS   = 31;
    localparam int STAT_W = 4;

    localparam int STAT_EXACT     = 0;
    localparam int STAT_OVERFLOW  = 1;
    localparam int STAT_UNDERFLOW = 2;
    localparam int STAT_INEXACT   = 3;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fpu_float_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_ROUND,
        S_DONE
    } fpu_state_e;

endpackage

// File: rtl/fpu_fixed_round.sv
// Combinational finishing stage: round-to-nearest-even on guard/sticky, then sign.
// Rounding is only compiled in when FPU_FIXED_ROUND_EN is defined; otherwise truncates.
module fpu_fixed_round
    import fpu_pkg::*;
(
    input  logic [31:0]       i_mag,
    input  logic              i_guard,
    input  logic              i_sticky,
    input  logic              i_sign,
    output logic [31:0]       o_data,
    output logic [STAT_W-1:0] o_status
);

    logic        w_inexact;
    logic [31:0] w_mag_fin;

    assign w_inexact = i_guard | i_sticky;

`ifdef FPU_FIXED_ROUND_EN
    assign w_mag_fin = i_mag + {31'd0, i_guard & (i_sticky | i_mag[0])};
`else
    assign w_mag_fin = i_mag;
`endif

    assign o_data = i_sign ? -w_mag_fin : w_mag_fin;

    always_comb begin
        o_status               = '0;
        o_status[STAT_EXACT]   = ~w_inexact;
        o_status[STAT_INEXACT] = w_inexact;
    end

endmodule

// File: rtl/fpu_to_fixed.sv
// Custom float to signed Q(32-FRAC_BITS).FRAC_BITS converter, one shift per cycle.
// FPU_FIXED_ROUND_EN selects a separate round-to-nearest-even cycle; else truncation.
module fpu_to_fixed
    import fpu_pkg::*;
#(
    parameter int FRAC_BITS = 16
) (
    input  logic        clock100KHz,
    input  logic        reset,
    input  logic [31:0] op_in,
    input  logic        op_valid_in,
    output logic        op_ready_out,
    output logic [31:0] data_out,
    output logic        data_valid_out,
    input  logic        data_ready_in,
    output logic [3:0]  status_out
);

    localparam logic signed [6:0] K_OFS = 7'(FRAC_BITS - BIAS - MAN_W);
`ifdef FPU_FIXED_ROUND_EN
    localparam fpu_state_e POST_SHIFT = S_ROUND;
`else
    localparam fpu_state_e POST_SHIFT = S_DONE;
`endif

    fpu_state_e        r_state, w_next;
    logic              r_sign, r_left, r_guard, r_sticky, r_valid;
    logic [5:0]        r_cnt;
    logic [31:0]       r_mag, r_data;
    logic [3:0]        r_status;

    fpu_float_t        w_op;
    logic signed [6:0] w_k;
    logic [5:0]        w_abs_k;
    logic              w_accept, w_special;
    logic [31:0]       w_spec_data, w_step_mag, w_rnd_mag, w_rnd_data;
    logic [3:0]        w_spec_status, w_rnd_status;
    logic              w_step_g, w_step_st, w_rnd_g, w_rnd_st, w_rnd_sign;

    assign w_op     = op_in;
    assign w_k      = $signed({1'b0, w_op.exp}) + K_OFS;
    assign w_abs_k  = w_k[6] ? 6'(-w_k) : 6'(w_k);
    assign w_accept = op_valid_in && (r_state == S_IDLE);

    always_comb begin
        w_special     = 1'b1;
        w_spec_data   = '0;
        w_spec_status = '0;
        if (w_op.exp == '0) begin
            if (w_op.man == '0) begin
                w_spec_status[STAT_EXACT] = 1'b1;
            end else begin
                w_spec_status[STAT_UNDERFLOW] = 1'b1;
                w_spec_status[STAT_INEXACT]   = 1'b1;
            end
        end else if (w_k > 7'sd6 || (w_k == 7'sd6 && (!w_op.sign || w_op.man != '0))) begin
            w_spec_data                  = w_op.sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
            w_spec_status[STAT_OVERFLOW] = 1'b1;
        end else if (w_k < -7'sd26) begin
            w_spec_status[STAT_UNDERFLOW] = 1'b1;
            w_spec_status[STAT_INEXACT]   = 1'b1;
        end else begin
            w_special = 1'b0;
        end
    end

    always_comb begin
        w_step_mag = r_mag;
        w_step_g   = r_guard;
        w_step_st  = r_sticky;
        if (r_left) begin
            w_step_mag = {r_mag[30:0], 1'b0};
        end else begin
            w_step_mag = {1'b0, r_mag[31:1]};
            w_step_g   = r_mag[0];
            w_step_st  = r_sticky | r_guard;
        end
    end

`ifdef FPU_FIXED_ROUND_EN
    assign w_rnd_mag  = r_mag;
    assign w_rnd_g    = r_guard;
    assign w_rnd_st   = r_sticky;
    assign w_rnd_sign = r_sign;
`else
    // Without a ROUND cycle the result is taken from the value being written this edge.
    always_comb begin
        w_rnd_mag  = r_mag;
        w_rnd_g    = r_guard;
        w_rnd_st   = r_sticky;
        w_rnd_sign = r_sign;
        if (r_state == S_IDLE) begin
            w_rnd_mag  = {6'd0, 1'b1, w_op.man};
            w_rnd_g    = 1'b0;
            w_rnd_st   = 1'b0;
            w_rnd_sign = w_op.sign;
        end else if (r_state == S_SHIFT) begin
            w_rnd_mag  = w_step_mag;
            w_rnd_g    = w_step_g;
            w_rnd_st   = w_step_st;
        end
    end
`endif

    fpu_fixed_round u_round (
        .i_mag    (w_rnd_mag),
        .i_guard  (w_rnd_g),
        .i_sticky (w_rnd_st),
        .i_sign   (w_rnd_sign),
        .o_data   (w_rnd_data),
        .o_status (w_rnd_status)
    );

    always_ff @(posedge clock100KHz) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_special)         w_next = S_DONE;
                    else if (w_k == 7'sd0) w_next = POST_SHIFT;
                    else                   w_next = S_SHIFT;
                end
            end
            S_SHIFT: if (r_cnt == 6'd1) w_next = POST_SHIFT;
            S_ROUND: w_next = S_DONE;
            S_DONE:  if (r_valid && data_ready_in) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        op_ready_out   = (r_state == S_IDLE);
        data_valid_out = r_valid;
        data_out       = r_data;
        status_out     = r_status;
    end

    // r_valid rises one edge after DONE is entered, giving the registered output stage.
    always_ff @(posedge clock100KHz) begin
        if (reset) begin
            r_sign   <= 1'b0;
            r_left   <= 1'b0;
            r_guard  <= 1'b0;
            r_sticky <= 1'b0;
            r_valid  <= 1'b0;
            r_cnt    <= '0;
            r_mag    <= '0;
            r_data   <= '0;
            r_status <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sign   <= w_op.sign;
                        r_left   <= (w_k > 7'sd0);
                        r_cnt    <= w_abs_k;
                        r_mag    <= {6'd0, 1'b1, w_op.man};
                        r_guard  <= 1'b0;
                        r_sticky <= 1'b0;
                        if (w_special) begin
                            r_data   <= w_spec_data;
                            r_status <= w_spec_status;
                        end
`ifndef FPU_FIXED_ROUND_EN
                        else if (w_k == 7'sd0) begin
                            r_data   <= w_rnd_data;
                            r_status <= w_rnd_status;
                        end
`endif
                    end
                end
                S_SHIFT: begin
                    r_mag    <= w_step_mag;
                    r_guard  <= w_step_g;
                    r_sticky <= w_step_st;
                    r_cnt    <= r_cnt - 6'd1;
`ifndef FPU_FIXED_ROUND_EN
                    if (r_cnt == 6'd1) begin
                        r_data   <= w_rnd_data;
                        r_status <= w_rnd_status;
                    end
`endif
                end
                S_ROUND: begin
                    r_data   <= w_rnd_data;
                    r_status <= w_rnd_status;
                end
                S_DONE: begin
                    if (!r_valid)          r_valid <= 1'b1;
                    else if (data_ready_in) r_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_to_fixed.sv
// Self-checking bench for fpu_to_fixed (FRAC_BITS=16); follows FPU_FIXED_ROUND_EN if defined.
module tb_fpu_to_fixed;

    localparam int FB = 16;
`ifdef FPU_FIXED_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] op_in = '0;
    logic        op_valid_in = 1'b0;
    logic        op_ready_out;
    logic [31:0] data_out;
    logic        data_valid_out;
    logic        data_ready_in = 1'b0;
    logic [3:0]  status_out;

    fpu_to_fixed #(.FRAC_BITS(FB)) dut (
        .clock100KHz    (clk),
        .reset          (reset),
        .op_in          (op_in),
        .op_valid_in    (op_valid_in),
        .op_ready_out   (op_ready_out),
        .data_out       (data_out),
        .data_valid_out (data_valid_out),
        .data_ready_in  (data_ready_in),
        .status_out     (status_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        pending  = 1'b0;
    int          issue_id = 0;
    logic [31:0] exp_d;
    logic [3:0]  exp_s;
    int          exp_lat;
    int          acc_cyc;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endfunction

    // Reference: value = sig * 2^k evaluated exactly in 64-bit integers.
    function automatic void model(input logic [31:0] op, output logic [31:0] d,
                                  output logic [3:0] st, output int lat);
        longint unsigned sig, mag, rem, half;
        longint v;
        int e, k;
        e   = int'(op[30:25]);
        k   = e - 31 + FB - 25;
        sig = {38'd0, 1'b1, op[24:0]};
        d   = '0;
        st  = '0;
        lat = 1;
        rem = 0;
        if (e == 0) begin
            st = (op[24:0] == '0) ? 4'b0001 : 4'b1100;
            return;
        end
        if (k < -26) begin
            st = 4'b1100;
            return;
        end
        if (k >= 0) begin
            mag = sig << k;
        end else begin
            mag  = sig >> (-k);
            rem  = sig - (mag << (-k));
            half = 64'd1 << (-k - 1);
            if (RND && (rem > half || (rem == half && mag[0]))) mag = mag + 1;
        end
        v = op[31] ? -longint'(mag) : longint'(mag);
        if (v > 64'sd2147483647 || v < -64'sd2147483648) begin
            d  = op[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            st = 4'b0010;
            return;
        end
        d   = v[31:0];
        st  = (rem != 0) ? 4'b1000 : 4'b0001;
        lat = (k < 0 ? -k : k) + (RND ? 2 : 1);
    endfunction

    // Single compare process: checks every cycle the result is presented.
    logic idle_chk = 1'b0;
    int   lat_id   = 0;
    always @(negedge clk) begin
        if (reset) begin
            idle_chk = 1'b0;
        end else if (idle_chk) begin
            chk("valid low after handshake", data_valid_out, 1'b0);
            chk("ready high after handshake", op_ready_out, 1'b1);
            idle_chk = 1'b0;
        end else if (data_valid_out) begin
            if (!pending) begin
                chk("unexpected valid", data_valid_out, 1'b0);
            end else begin
                chk("data", data_out, exp_d);
                chk("status", status_out, exp_s);
                chk("ready low in DONE", op_ready_out, 1'b0);
                if (lat_id != issue_id) begin
                    chk("latency", cyc - acc_cyc, exp_lat);
                    lat_id = issue_id;
                end
                if (data_ready_in) idle_chk = 1'b1;
            end
        end
    end

    task automatic run_op(input string nm, input logic [31:0] op, input logic [31:0] ld,
                          input logic [3:0] ls, input int llat, input int hold);
        logic [31:0] md;
        logic [3:0]  ms;
        int          ml;
        int          n;
        model(op, md, ms, ml);
        chk({nm, " model data"}, md, ld);
        chk({nm, " model status"}, ms, ls);
        chk({nm, " model latency"}, ml, llat);
        @(posedge clk); #1;
        n = 0;
        while (!op_ready_out && n < 100) begin @(posedge clk); #1; n++; end
        chk({nm, " ready before issue"}, op_ready_out, 1'b1);
        exp_d   = md;
        exp_s   = ms;
        exp_lat = ml;
        issue_id++;
        pending = 1'b1;
        op_in = op;
        op_valid_in = 1'b1;
        @(posedge clk); #1;
        acc_cyc = cyc;
        op_in = $urandom;
        @(posedge clk); #1;
        op_valid_in = 1'b0;
        op_in = $urandom;
        n = 0;
        while (!data_valid_out && n < 100) begin @(posedge clk); #1; n++; end
        chk({nm, " valid within bound"}, data_valid_out, 1'b1);
        repeat (hold) begin @(posedge clk); #1; end
        data_ready_in = 1'b1;
        @(posedge clk); #1;
        data_ready_in = 1'b0;
        @(negedge clk); #1;
        pending = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset ready", op_ready_out, 1'b1);
        chk("reset valid", data_valid_out, 1'b0);
        chk("reset data", data_out, 32'h0);
        chk("reset status", status_out, 4'h0);

        run_op("+1.0",       32'h3E00_0000, 32'h0001_0000, 4'b0001, RND ? 11 : 10, 1);
        run_op("-2.0",       32'hC000_0000, 32'hFFFE_0000, 4'b0001, RND ? 10 : 9, 0);
        run_op("+0",         32'h0000_0000, 32'h0000_0000, 4'b0001, 1, 0);
        run_op("-0",         32'h8000_0000, 32'h0000_0000, 4'b0001, 1, 2);
        run_op("0.75 lsb",   32'h1D00_0000, RND ? 32'h1 : 32'h0, 4'b1000, RND ? 28 : 27, 0);
        run_op("0.5 lsb",    32'h1C00_0000, 32'h0000_0000, 4'b1000, RND ? 28 : 27, 0);
        run_op("1.5 lsb",    32'h1F00_0000, RND ? 32'h2 : 32'h1, 4'b1000, RND ? 27 : 26, 0);
        run_op("max ovf",    32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'b0010, 1, 0);
        run_op("-2^31",      32'hDC00_0000, 32'h8000_0000, 4'b0001, RND ? 8 : 7, 0);
        run_op("+2^31 ovf",  32'h5C00_0000, 32'h7FFF_FFFF, 4'b0010, 1, 0);
        run_op("k=0",        32'h5000_0000, 32'h0200_0000, 4'b0001, RND ? 2 : 1, 0);
        run_op("-1 inexact", 32'hBE00_0001, 32'hFFFF_0000, 4'b1000, RND ? 11 : 10, 0);
        run_op("k=-27",      32'h1A00_0000, 32'h0000_0000, 4'b1100, 1, 0);
        run_op("denorm",     32'h0200_0001, 32'h0000_0000, 4'b1100, 1, 5);

        // Reset during SHIFT abandons the conversion.
        @(posedge clk); #1;
        op_in = 32'h3E00_0000;
        op_valid_in = 1'b1;
        @(posedge clk); #1;
        op_valid_in = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid reset valid", data_valid_out, 1'b0);
        chk("mid reset ready", op_ready_out, 1'b1);
        chk("mid reset data", data_out, 32'h0);
        repeat (15) @(negedge clk);
        chk("no output after reset", data_valid_out, 1'b0);

        run_op("after reset", 32'hC000_0000, 32'hFFFE_0000, 4'b0001, RND ? 10 : 9, 0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
